// File: rtl/craft_pkg.sv
// rtl/craft_pkg.sv - CRAFT cipher constants, FSM encoding and nibble-wise helpers
package craft_pkg;

  localparam int ROUNDS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
    4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  localparam logic [3:0] PERM [16] = '{
    4'd15, 4'd12, 4'd13, 4'd14, 4'd10, 4'd9, 4'd8, 4'd11,
    4'd6,  4'd5,  4'd4,  4'd7,  4'd1,  4'd2, 4'd3, 4'd0
  };

  // Upper nibble is the 4-bit LFSR value, lower nibble the 3-bit one (bit 3 always 0).
  localparam logic [7:0] RC_TABLE [32] = '{
    8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h63, 8'hB1,
    8'h54, 8'hA2, 8'hD5, 8'hE6, 8'hF7, 8'h73, 8'h31, 8'h14,
    8'h82, 8'h45, 8'h26, 8'h97, 8'hC3, 8'h61, 8'hB4, 8'h52,
    8'hA5, 8'hD6, 8'hE7, 8'hF3, 8'h71, 8'h34, 8'h12, 8'h85
  };

  function automatic logic [63:0] sb64(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      r[4*j +: 4] = SBOX[s[4*j +: 4]];
    end
    return r;
  endfunction

  // Nibble 0 sits at bits [63:60]; new[j] = old[PERM[j]].
  function automatic logic [63:0] pn64(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      r[63-4*j -: 4] = s[63-4*int'(PERM[j]) -: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] mc64(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    r[63:48] = s[63:48] ^ s[31:16] ^ s[15:0];
    r[47:32] = s[47:32] ^ s[15:0];
    return r;
  endfunction

endpackage

// File: rtl/craft_inv_round.sv
// rtl/craft_inv_round.sv - one combinational CRAFT inverse round (SB, PN, ATK, ARC, MC)
module craft_inv_round
  import craft_pkg::*;
(
  input  logic [63:0] s,
  input  logic [63:0] tk,
  input  logic [7:0]  rc,
  input  logic        first,
  output logic [63:0] s_next
);

  logic [63:0] w_perm;
  logic [63:0] w_keyed;

  // The final encryption round has no SB/PN, so its inverse skips them.
  assign w_perm  = first ? s : pn64(sb64(s));
  assign w_keyed = w_perm ^ tk ^ {16'h0, rc, 40'h0};
  assign s_next  = mc64(w_keyed);

endmodule

// File: rtl/craft_key_schedule.sv
// rtl/craft_key_schedule.sv - CRAFT tweakey selection TK[r mod 4] from key and tweak
module craft_key_schedule (
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  input  logic [4:0]   r,
  output logic [63:0]  tk
);

  localparam logic [3:0] QPERM [16] = '{
    4'd12, 4'd10, 4'd15, 4'd5, 4'd14, 4'd8, 4'd9, 4'd2,
    4'd11, 4'd3,  4'd7,  4'd4, 4'd6,  4'd0, 4'd1, 4'd13
  };

  logic [63:0] w_tq;
  logic [1:0]  w_sel;

  assign w_sel = 2'(r % 5'd4);

  always_comb begin
    w_tq = '0;
    for (int j = 0; j < 16; j++) begin
      w_tq[63-4*j -: 4] = tweak[63-4*int'(QPERM[j]) -: 4];
    end
  end

  always_comb begin
    tk = '0;
    unique case (w_sel)
      2'd0: tk = key[127:64] ^ tweak;
      2'd1: tk = key[63:0]   ^ tweak;
      2'd2: tk = key[127:64] ^ w_tq;
      2'd3: tk = key[63:0]   ^ w_tq;
      default: tk = '0;
    endcase
  end

endmodule

// File: rtl/craft_decrypt_core.sv
// rtl/craft_decrypt_core.sv - iterative CRAFT-64/128 decryption, one inverse round per cycle
module craft_decrypt_core
  import craft_pkg::*;
#(
  parameter int ROUNDS = craft_pkg::ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  ct,
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  pt
);

  state_t       r_state;
  state_t       w_next;
  logic [63:0]  r_s;
  logic [127:0] r_key;
  logic [63:0]  r_tweak;
  logic [4:0]   r_k;
  logic [63:0]  r_pt;
  logic [4:0]   w_i;
  logic         w_last;
  logic [63:0]  w_tk;
  logic [63:0]  w_s_next;

  // Inverse step k undoes encryption round i = ROUNDS-1-k.
  assign w_i    = 5'(ROUNDS - 1) - r_k;
  assign w_last = (r_k == 5'(ROUNDS - 1));

  craft_key_schedule u_ks (
    .key   (r_key),
    .tweak (r_tweak),
    .r     (w_i),
    .tk    (w_tk)
  );

  craft_inv_round u_round (
    .s      (r_s),
    .tk     (w_tk),
    .rc     (RC_TABLE[w_i]),
    .first  (r_k == 5'd0),
    .s_next (w_s_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Key and tweak are captured once so later input changes cannot disturb a job.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= '0;
      r_key   <= '0;
      r_tweak <= '0;
      r_k     <= '0;
      r_pt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s     <= ct;
            r_key   <= key;
            r_tweak <= tweak;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          r_s <= w_s_next;
          r_k <= r_k + 5'd1;
          if (w_last) r_pt <= w_s_next;
        end
        default: ;
      endcase
    end
  end

  assign pt = r_pt;

endmodule

// File: tb/tb_craft_decrypt_core.sv
// tb/tb_craft_decrypt_core.sv - scoreboard bench: encryption model feeds ciphertexts, monitor checks plaintexts
module tb_craft_decrypt_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  ct;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  pt;

  craft_decrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .tweak     (tweak),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit stuck = 0;

  typedef struct {
    logic [63:0] pt;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  int   rise_q[$];

  localparam logic [127:0] KAT_KEY = 128'h27A6781A43F364BC916708D5FBB5AEFE;
  localparam logic [63:0]  KAT_TW  = 64'h54CD94FFD0670A58;
  localparam logic [63:0]  KAT_PT  = 64'h5734F006D8D88A3E;

  logic [3:0] s_tb [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                            4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
  int p_tb [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  int q_tb [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  function automatic logic [63:0] tb_perm(input logic [63:0] x, input bit use_q);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) begin
      y[63-4*j -: 4] = x[63-4*(use_q ? q_tb[j] : p_tb[j]) -: 4];
    end
    return y;
  endfunction

  function automatic logic [63:0] tb_sb(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[4*j +: 4] = s_tb[x[4*j +: 4]];
    return y;
  endfunction

  function automatic logic [63:0] tb_mc(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[63-4*c -: 4];
      a1 = x[63-4*(4+c) -: 4];
      a2 = x[63-4*(8+c) -: 4];
      a3 = x[63-4*(12+c) -: 4];
      y[63-4*c -: 4]      = a0 ^ a2 ^ a3;
      y[63-4*(4+c) -: 4]  = a1 ^ a3;
      y[63-4*(8+c) -: 4]  = a2;
      y[63-4*(12+c) -: 4] = a3;
    end
    return y;
  endfunction

  // Forward CRAFT encryption with LFSR-generated round constants.
  function automatic logic [63:0] enc(input logic [63:0] p, input logic [127:0] k, input logic [63:0] t);
    logic [63:0] s, tq, tk;
    logic [3:0]  a;
    logic [2:0]  b;
    s  = p;
    a  = 4'h1;
    b  = 3'h1;
    tq = tb_perm(t, 1'b1);
    for (int i = 0; i < 32; i++) begin
      s = tb_mc(s);
      s[47:44] = s[47:44] ^ a;
      s[43:40] = s[43:40] ^ {1'b0, b};
      case (i % 4)
        0:       tk = k[127:64] ^ t;
        1:       tk = k[63:0]   ^ t;
        2:       tk = k[127:64] ^ tq;
        default: tk = k[63:0]   ^ tq;
      endcase
      s = s ^ tk;
      if (i != 31) s = tb_sb(tb_perm(s, 1'b0));
      a = {a[0] ^ a[1], a[3:1]};
      b = {b[0] ^ b[1], b[2:1]};
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected event expected none", nm);
  endtask

  task automatic send(input logic [63:0] c, input logic [127:0] k, input logic [63:0] t,
                      input logic [63:0] exp, input bit hold);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail("send_wait_in_ready");
      stuck = 1;
      return;
    end
    ct = c; key = k; tweak = t; in_valid = 1'b1;
    exp_q.push_back('{pt: exp, acc: cyc});
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    key   = ~k;
    tweak = ~t;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail("drain_timeout");
      exp_q.delete();
    end
  endtask

  // Monitor: latency on each out_valid rise, plaintext on each accepted output.
  initial begin
    bit   prev_ov = 0;
    exp_t it;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) fail("unexpected_out_valid");
        else chk("latency", 64'(cyc - exp_q[0].acc), 64'd33);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        it = exp_q.pop_front();
        chk("pt", pt, it.pt);
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    logic [63:0]  kat_ct, vp, vt;
    logic [127:0] vk;
    logic [63:0]  b2b_pt [3];
    logic [127:0] b2b_key [3];
    logic [63:0]  b2b_tw [3];
    int n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ct = '0; key = '0; tweak = '0;
    kat_ct = enc(KAT_PT, KAT_KEY, KAT_TW);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_pt", pt, 64'd0);

    // Known answer with backpressure on the output.
    out_ready = 1'b0;
    send(kat_ct, KAT_KEY, KAT_TW, KAT_PT, 1'b0);
    repeat (31) @(posedge clk);
    @(negedge clk);
    chk("tk_round0", dut.w_tk, 64'h736BECE593946EE4);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("kat_wait_out_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_pt", pt, KAT_PT);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    wait_drain();

    // Busy input: a second ciphertext during RUN must be dropped.
    vp = 64'h0123456789ABCDEF; vk = {64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978}; vt = 64'hA5A5A5A55A5A5A5A;
    send(enc(vp, vk, vt), vk, vt, vp, 1'b0);
    repeat (4) @(posedge clk);
    #1 ct = 64'hDEADBEEFDEADBEEF; key = '1; tweak = '0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain();
    send(kat_ct, KAT_KEY, KAT_TW, KAT_PT, 1'b0);
    wait_drain();

    // Reset while RUN at round 16 drops the job.
    send(enc(vp, vk, vt), vk, vt, vp, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_pt", pt, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    send(kat_ct, KAT_KEY, KAT_TW, KAT_PT, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high.
    b2b_pt[0] = 64'h0;               b2b_key[0] = '0;  b2b_tw[0] = '0;
    b2b_pt[1] = 64'hFFFFFFFFFFFFFFFF; b2b_key[1] = '1; b2b_tw[1] = '1;
    b2b_pt[2] = KAT_PT;              b2b_key[2] = KAT_KEY; b2b_tw[2] = KAT_TW;
    rise_q.delete();
    for (int i = 0; i < 3; i++) begin
      send(enc(b2b_pt[i], b2b_key[i], b2b_tw[i]), b2b_key[i], b2b_tw[i], b2b_pt[i], 1'b1);
    end
    in_valid = 1'b0;
    wait_drain();
    chk("b2b_count", 64'(rise_q.size()), 64'd3);
    if (rise_q.size() == 3) begin
      chk("b2b_period01", 64'(rise_q[1] - rise_q[0]), 64'd34);
      chk("b2b_period12", 64'(rise_q[2] - rise_q[1]), 64'd34);
    end

    // Random round trips.
    for (int i = 0; i < 1000 && !stuck; i++) begin
      vp = {$urandom, $urandom};
      vk = {$urandom, $urandom, $urandom, $urandom};
      vt = {$urandom, $urandom};
      send(enc(vp, vk, vt), vk, vt, vp, 1'b0);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
